// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op-code values and the per-result
// flag bundle carried through both pipeline stages.
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_SRL  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_SRA  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_ADDC = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_SUBC = 4'hD;

  // Flag part of the stage payload; the result word travels beside it because
  // its width is a per-instance parameter.
  typedef struct packed {
    logic carry;
    logic zero;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/writeback bus of the pipelined ALU.
//   slave  : ALU side (takes operations, drives results)
//   master : issue/writeback side
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHIFT_W = $clog2(WIDTH);

  logic                          in_valid;
  logic                          in_ready;
  logic [alu_pkg::OPCODE_W-1:0]  op_code;
  logic [WIDTH-1:0]              operand_1;
  logic [WIDTH-1:0]              operand_2;
  logic [SHIFT_W-1:0]            shift_rotate;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              result;
  logic                          carry;
  logic                          zero;
  logic                          illegal;

  modport slave (
    input  in_valid, op_code, operand_1, operand_2, shift_rotate, out_ready,
    output in_ready, out_valid, result, carry, zero, illegal
  );

  modport master (
    output in_valid, op_code, operand_1, operand_2, shift_rotate, out_ready,
    input  in_ready, out_valid, result, carry, zero, illegal
  );

endinterface

// File: rtl/alu_exec.sv
// Combinational ALU core.
//   op_code, operand_1, operand_2, shift_rotate, c_in -> result, flags
// Arithmetic runs at WIDTH+1 bits; bit WIDTH is the carry (add) or borrow (sub).
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = $clog2(WIDTH)
) (
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [WIDTH-1:0]    operand_1,
  input  logic [WIDTH-1:0]    operand_2,
  input  logic [SHIFT_W-1:0]  shift_rotate,
  input  logic                c_in,
  output logic [WIDTH-1:0]    result,
  output alu_flags_t          flags
);

  localparam int unsigned W1    = WIDTH + 1;
  localparam int unsigned AMT_W = SHIFT_W + 1;
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     ext_b;
  logic               use_cin;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     sub_res;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     shr;
  logic [WIDTH:0]     sra;
  logic [AMT_W-1:0]   inv_amt;
  logic [WIDTH-1:0]   rol;
  logic [WIDTH-1:0]   ror;
  logic               amt_nz;
  logic [WIDTH-1:0]   res;
  logic               cy;
  logic               ill;

  always_comb begin
    ext_a   = {1'b0, operand_1};
    ext_b   = {1'b0, operand_2};
    use_cin = (op_code == OP_ADDC) || (op_code == OP_SUBC);
    add_res = ext_a + ext_b + W1'(c_in & use_cin);
    sub_res = ext_a - ext_b - W1'(c_in & use_cin);
    amt_nz  = (shift_rotate != '0);

    // Shifts carry one guard bit so the last bit shifted out lands in it;
    // with a zero amount the guard bit stays 0.
    shl = ext_a << shift_rotate;
    shr = {operand_1, 1'b0} >> shift_rotate;
    sra = $unsigned($signed({operand_1, 1'b0}) >>> shift_rotate);

    // Shifting by WIDTH clears the wrap-around term, so amount 0 is a no-op.
    inv_amt = WIDTH_AMT - {1'b0, shift_rotate};
    rol     = (operand_1 << shift_rotate) | (operand_1 >> inv_amt);
    ror     = (operand_1 >> shift_rotate) | (operand_1 << inv_amt);

    res = '0;
    cy  = 1'b0;
    ill = 1'b0;
    case (op_code)
      OP_AND:  res = operand_1 & operand_2;
      OP_OR:   res = operand_1 | operand_2;
      OP_XOR:  res = operand_1 ^ operand_2;
      OP_NOT:  res = ~operand_1;
      OP_ADD, OP_ADDC: begin
        res = add_res[WIDTH-1:0];
        cy  = add_res[WIDTH];
      end
      OP_SUB, OP_SUBC: begin
        res = sub_res[WIDTH-1:0];
        cy  = sub_res[WIDTH];
      end
      OP_SRL: begin
        res = shr[WIDTH:1];
        cy  = shr[0];
      end
      OP_SLL: begin
        res = shl[WIDTH-1:0];
        cy  = shl[WIDTH];
      end
      OP_SRA: begin
        res = sra[WIDTH:1];
        cy  = sra[0];
      end
      OP_ROL: begin
        res = rol;
        cy  = amt_nz & rol[0];
      end
      OP_ROR: begin
        res = ror;
        cy  = amt_nz & ror[WIDTH-1];
      end
      default: ill = 1'b1;
    endcase

    result        = res;
    flags.carry   = cy;
    flags.zero    = (res == '0);
    flags.illegal = ill;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
//   clk, reset_n (async, active-low), clear (synchronous flush)
//   bus : alu_pipe_if.slave -- operation in, result/carry/zero/illegal out
// S1 holds the freshly executed op, S2 drives the outputs. carry_flag chains
// ADDC/SUBC and is updated at accept time so back-to-back ops never stall.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  alu_pipe_if.slave  bus
);

  localparam int unsigned SHIFT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] exec_result;
  alu_flags_t       exec_flags;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  alu_flags_t       s1_flags;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  alu_flags_t       s2_flags;
  logic             carry_flag;

  logic             s2_load_c;
  logic             s1_free_c;
  logic             accept_c;

  alu_exec #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_exec (
    .op_code      (bus.op_code),
    .operand_1    (bus.operand_1),
    .operand_2    (bus.operand_2),
    .shift_rotate (bus.shift_rotate),
    .c_in         (carry_flag),
    .result       (exec_result),
    .flags        (exec_flags)
  );

  // Stage advance conditions; in_ready depends only on state, out_ready and clear.
  assign s2_load_c    = !s2_valid || bus.out_ready;
  assign s1_free_c    = !s1_valid || s2_load_c;
  assign bus.in_ready = s1_free_c && !clear;
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Pipeline registers and chained carry; clear outranks accept and advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_flags   <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_flags   <= '0;
      carry_flag <= 1'b0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      if (s2_load_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= s1_result;
          s2_flags  <= s1_flags;
        end
      end
      if (s1_free_c) begin
        s1_valid <= accept_c;
      end
      if (accept_c) begin
        s1_result <= exec_result;
        s1_flags  <= exec_flags;
        if (!exec_flags.illegal) begin
          carry_flag <= exec_flags.carry;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.carry     = s2_flags.carry;
  assign bus.zero      = s2_flags.zero;
  assign bus.illegal   = s2_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an 8-bit and a 16-bit instance on a shared clock/reset,
// checked against an arithmetic reference model and a result queue.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8))  bus8();
  alu_pipe_if #(.WIDTH(16)) bus16();

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus16)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mcf8  = 1'b0;
  bit mcf16 = 1'b0;

  // Reference: returns {illegal, zero, carry, result[15:0]} for width w.
  function automatic logic [18:0] model(input int w, input int op, input longint a,
                                        input longint b, input int n, input bit cin);
    longint m;
    longint full;
    longint r;
    longint sa;
    bit c;
    bit ill;
    full = longint'(1) << w;
    m    = full - 1;
    r    = 0;
    c    = 1'b0;
    ill  = 1'b0;
    case (op)
      1:  r = a & b;
      2:  r = a | b;
      3:  r = a ^ b;
      4:  r = m - a;
      5:  begin r = a + b;       c = (r > m); end
      6:  begin r = a - b;       c = (a < b); end
      12: begin r = a + b + cin; c = (r > m); end
      13: begin r = a - b - cin; c = (a < b + cin); end
      7:  begin r = a >> n; c = (n > 0) && (((a >> (n - 1)) & 1) != 0); end
      8:  begin r = a << n; c = (n > 0) && (((a >> (w - n)) & 1) != 0); end
      9: begin
        sa = (a >= full / 2) ? a - full : a;
        r  = sa >>> n;
        c  = (n > 0) && (((a >> (n - 1)) & 1) != 0);
      end
      10: begin
        r = ((a << n) | (a >> (w - n))) & m;
        c = (n > 0) && ((r & 1) != 0);
      end
      11: begin
        r = ((a >> n) | (a << (w - n))) & m;
        c = (n > 0) && (((r >> (w - 1)) & 1) != 0);
      end
      default: ill = 1'b1;
    endcase
    r = r & m;
    return {ill, (r == 0), c, 16'(r)};
  endfunction

  // Drives one op on bus8 with out_ready=1 and captures its result.
  task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] n, output logic [10:0] obs, output int lat,
                         output bit timeout);
    logic [18:0] m;
    obs = '0;
    lat = -1;
    timeout = 1'b1;
    bus8.out_ready    = 1'b1;
    bus8.in_valid     = 1'b1;
    bus8.op_code      = op;
    bus8.operand_1    = a;
    bus8.operand_2    = b;
    bus8.shift_rotate = n;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (timeout) begin
      bus8.in_valid = 1'b0;
      return;
    end
    m = model(8, int'(op), longint'(a), longint'(b), int'(n), mcf8);
    if (!m[18]) mcf8 = m[16];
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        obs = {bus8.illegal, bus8.zero, bus8.carry, bus8.result};
        lat = k;
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Same driver for the 16-bit instance.
  task automatic run_op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] n, output logic [18:0] obs, output bit timeout);
    logic [18:0] m;
    obs = '0;
    timeout = 1'b1;
    bus16.out_ready    = 1'b1;
    bus16.in_valid     = 1'b1;
    bus16.op_code      = op;
    bus16.operand_1    = a;
    bus16.operand_2    = b;
    bus16.shift_rotate = n;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus16.in_ready) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (timeout) begin
      bus16.in_valid = 1'b0;
      return;
    end
    m = model(16, int'(op), longint'(a), longint'(b), int'(n), mcf16);
    if (!m[18]) mcf16 = m[16];
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus16.out_valid) begin
        obs = {bus16.illegal, bus16.zero, bus16.carry, bus16.result};
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [11:0] st8;
    logic [19:0] st16;
    #12;
    st8  = {bus8.out_valid, bus8.illegal, bus8.zero, bus8.carry, bus8.result};
    st16 = {bus16.out_valid, bus16.illegal, bus16.zero, bus16.carry, bus16.result};
    n_checks++;
    if (st8 !== 12'h000) $display("FAIL reset_state8: got %h expected 000", st8);
    else n_pass++;
    n_checks++;
    if (st16 !== 20'h00000) $display("FAIL reset_state16: got %h expected 00000", st16);
    else n_pass++;
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus8.in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [14] = '{OP_ADD, OP_ADDC, OP_SUB, OP_SUB, OP_SUBC, OP_SRA, 4'hE,
                              OP_ADDC, OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_ADDC, OP_NOT};
    logic [7:0]  va  [14] = '{8'hF0, 8'h00, 8'h05, 8'h03, 8'h10, 8'h81, 8'h81,
                              8'h00, 8'h81, 8'h81, 8'h81, 8'h81, 8'h01, 8'h0F};
    logic [7:0]  vb  [14] = '{8'h20, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h55,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    logic [2:0]  vn  [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3,
                              3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
    // {illegal, zero, carry, result}
    logic [10:0] ve  [14] = '{11'h110, 11'h001, 11'h200, 11'h1FE, 11'h00F, 11'h1C0, 11'h600,
                              11'h001, 11'h103, 11'h081, 11'h1C0, 11'h140, 11'h003, 11'h0F0};
    logic [10:0] obs;
    int lat;
    bit to;
    for (int i = 0; i < 14; i++) begin
      run_op8(ops[i], va[i], vb[i], vn[i], obs, lat, to);
      n_checks++;
      if (to) $display("FAIL directed_%0d_timeout: op %h never completed", i, ops[i]);
      else n_pass++;
      n_checks++;
      if (obs !== ve[i])
        $display("FAIL directed_%0d op=%h a=%h b=%h n=%0d: got %h expected %h",
                 i, ops[i], va[i], vb[i], vn[i], obs, ve[i]);
      else n_pass++;
      if (i == 0) begin
        // Presented in cycle N, one cycle in S1, visible in cycle N+2.
        n_checks++;
        if (lat != 1) $display("FAIL latency: got %0d idle cycles expected 1", lat);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] q[$];
    logic [10:0] obs;
    logic [10:0] prev_obs;
    logic [10:0] exp;
    logic [18:0] m;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_obs = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        bus8.in_valid     = ($urandom_range(3) != 0);
        bus8.op_code      = 4'($urandom_range(15));
        bus8.operand_1    = 8'($urandom);
        bus8.operand_2    = 8'($urandom);
        bus8.shift_rotate = 3'($urandom);
        bus8.out_ready    = ($urandom_range(2) != 0);
      end else begin
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
      end
      @(negedge clk);
      obs = {bus8.illegal, bus8.zero, bus8.carry, bus8.result};
      if (prev_stall) begin
        n_checks++;
        if (bus8.out_valid !== 1'b1 || obs !== prev_obs)
          $display("FAIL stall_hold cyc=%0d: got v=%b %h expected v=1 %h",
                   cyc, bus8.out_valid, obs, prev_obs);
        else n_pass++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL random_extra cyc=%0d: got result %h expected none", cyc, obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) $display("FAIL random_result cyc=%0d: got %h expected %h", cyc, obs, exp);
          else n_pass++;
        end
      end
      prev_stall = bus8.out_valid && !bus8.out_ready;
      prev_obs   = obs;
      if (bus8.in_valid && bus8.in_ready) begin
        m = model(8, int'(bus8.op_code), longint'(bus8.operand_1), longint'(bus8.operand_2),
                  int'(bus8.shift_rotate), mcf8);
        if (!m[18]) mcf8 = m[16];
        q.push_back({m[18:16], m[7:0]});
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL random_drain: got %0d results left expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic [10:0] q[$];
    logic [10:0] obs;
    logic [10:0] exp;
    logic [18:0] m;
    int sent;
    int got;
    for (int i = 0; i < 6; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
    sent = 0;
    got  = 0;
    bus8.out_ready = 1'b0;
    bus8.op_code   = OP_ADD;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (cyc == 5) bus8.out_ready = 1'b1;
      bus8.in_valid = (sent < 6);
      if (sent < 6) begin
        bus8.operand_1 = va[sent];
        bus8.operand_2 = vb[sent];
      end
      @(negedge clk);
      if (cyc < 5) begin
        n_checks++;
        if (bus8.in_ready !== (sent < 2))
          $display("FAIL bp_in_ready cyc=%0d: got %b expected %b", cyc, bus8.in_ready, (sent < 2));
        else n_pass++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        obs = {bus8.illegal, bus8.zero, bus8.carry, bus8.result};
        got++;
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL bp_extra: got result %h expected none", obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) $display("FAIL bp_order #%0d: got %h expected %h", got, obs, exp);
          else n_pass++;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        m = model(8, 5, longint'(va[sent]), longint'(vb[sent]), 0, mcf8);
        mcf8 = m[16];
        q.push_back({m[18:16], m[7:0]});
        sent++;
      end
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    n_checks++;
    if (got != 6 || sent != 6 || q.size() != 0)
      $display("FAIL bp_count: got %0d delivered of %0d sent expected 6 of 6", got, sent);
    else n_pass++;
  endtask

  task automatic test_clear();
    logic [10:0] obs;
    int lat;
    bit to;
    int acc;
    acc = 0;
    bus8.out_ready = 1'b0;
    bus8.op_code   = OP_ADD;
    bus8.operand_1 = 8'hFF;
    bus8.operand_2 = 8'hFF;
    bus8.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
      @(negedge clk);
      if (bus8.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    mcf8 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (acc != 2 || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0)
      $display("FAIL clear_setup: got acc=%0d v=%b rdy=%b expected 2 1 0",
               acc, bus8.out_valid, bus8.in_ready);
    else n_pass++;
    clear = 1'b1;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.op_code   = OP_ADDC;
    #1;
    n_checks++;
    if (bus8.in_ready !== 1'b0) $display("FAIL clear_in_ready: got %b expected 0", bus8.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    clear = 1'b0;
    bus8.in_valid = 1'b0;
    mcf8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus8.out_valid !== 1'b0) $display("FAIL clear_flush: got out_valid=%b expected 0", bus8.out_valid);
    else n_pass++;
    @(posedge clk); #1;
    run_op8(OP_ADDC, 8'h01, 8'h01, 3'd0, obs, lat, to);
    n_checks++;
    if (to || obs !== 11'h002) $display("FAIL clear_carry: got %h (timeout=%b) expected 002", obs, to);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.op_code   = OP_ADD;
    bus8.operand_1 = 8'hF0;
    bus8.operand_2 = 8'h20;
    bus8.in_valid  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!seen || bus8.result !== 8'h10 || bus8.carry !== 1'b1)
      $display("FAIL areset_setup: got v=%b res=%h c=%b expected 1 10 1",
               bus8.out_valid, bus8.result, bus8.carry);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus8.out_valid, bus8.result, bus8.carry} !== 10'h000)
      $display("FAIL areset_clear: got v=%b res=%h c=%b expected 0 00 0",
               bus8.out_valid, bus8.result, bus8.carry);
    else n_pass++;
    mcf8  = 1'b0;
    mcf16 = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0)
      $display("FAIL areset_release: got rdy=%b v=%b expected 1 0", bus8.in_ready, bus8.out_valid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    logic [18:0] obs;
    logic [18:0] exp;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  n;
    bit to;
    run_op16(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, obs, to);
    n_checks++;
    if (to || obs !== 19'h30000) $display("FAIL w16_add_wrap: got %h (timeout=%b) expected 30000", obs, to);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      n  = 4'($urandom);
      exp = model(16, int'(op), longint'(a), longint'(b), int'(n), mcf16);
      run_op16(op, a, b, n, obs, to);
      n_checks++;
      if (to || obs !== exp)
        $display("FAIL w16_random_%0d op=%h a=%h b=%h n=%0d: got %h expected %h",
                 i, op, a, b, n, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.op_code = '0;
    bus8.operand_1 = '0;   bus8.operand_2 = '0;    bus8.shift_rotate = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.op_code = '0;
    bus16.operand_1 = '0;  bus16.operand_2 = '0;   bus16.shift_rotate = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_width16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, %0d of %0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
